// File: rtl/cnn_pkg.sv
// Shared constants and types for the conv-layer bias path.
package cnn_pkg;

  // Bias / stream byte width.
  localparam int DW = 8;

  // Default out_channels - 1; RAM depth is OC_DEFAULT + 1.
  localparam int OC_DEFAULT = 7;

  // Loader FSM: waiting for start, taking bias bytes, taking the checksum byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CSUM = 2'd2
  } bias_ld_state_t;

endpackage

// File: rtl/bias_ram_loader_if.sv
// Byte-stream valid/ready link feeding the bias loader.
interface bias_ram_loader_if;
  import cnn_pkg::*;

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  // Producer side (host / UART front-end).
  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  // Consumer side (the loader).
  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/bias_ram.sv
// Bias storage: one synchronous write port, one registered read port.
// Reads see the pre-write contents on an address collision, and any
// channel index beyond the table returns zero.
module bias_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [3:0]       raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [3:0] MAX_ADDR = 4'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; non-blocking ordering gives read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      if (raddr > MAX_ADDR) begin
        rdata_reg <= '0;
      end else begin
        rdata_reg <= mem[raddr[AW-1:0]];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bias_ram_loader.sv
// Run-time bias loader: takes OC+1 bias bytes plus a trailing 8-bit checksum
// over a valid/ready stream, writes them into the bias RAM and flags whether
// the table verified. The RAM read port serves the conv datapath throughout.
module bias_ram_loader
  import cnn_pkg::*;
#(
  parameter int OC = OC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  bias_ram_loader_if.slave   s_if,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               loaded,
  input  logic               c_load,
  input  logic [3:0]         cout,
  output logic [DW-1:0]      bias
);

  localparam int            AW        = (OC > 0) ? $clog2(OC + 1) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(OC);

  bias_ld_state_t state_reg, state_next;
  logic [AW-1:0]  addr_reg, addr_next;
  logic [DW-1:0]  sum_reg, sum_next;
  logic           err_reg, err_next;
  logic           loaded_reg, loaded_next;
  logic           done_reg, done_next;
  logic           accept;
  logic           wr_en;

  // Ready whenever a load is in progress; the loader never stalls a byte.
  assign s_if.s_ready = (state_reg != IDLE);
  assign accept       = s_if.s_valid && (state_reg != IDLE);

  // State, address, checksum and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      sum_reg    <= '0;
      err_reg    <= 1'b0;
      loaded_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      sum_reg    <= sum_next;
      err_reg    <= err_next;
      loaded_reg <= loaded_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic: start a load, stream bias bytes, then judge the checksum.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    sum_next    = sum_reg;
    err_next    = err_reg;
    loaded_next = loaded_reg;
    done_next   = 1'b0;
    wr_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = LOAD;
          addr_next   = '0;
          sum_next    = '0;
          err_next    = 1'b0;
          loaded_next = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en     = 1'b1;
          sum_next  = sum_reg + s_if.s_data;
          addr_next = addr_reg + 1'b1;
          if (addr_reg == LAST_ADDR) begin
            state_next = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          err_next    = (s_if.s_data != sum_reg);
          loaded_next = (s_if.s_data == sum_reg);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;
  assign err    = err_reg;
  assign loaded = loaded_reg;

  bias_ram #(
    .DEPTH (OC + 1),
    .AW    (AW),
    .WIDTH (DW)
  ) u_bias_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (addr_reg),
    .wdata (s_if.s_data),
    .re    (c_load),
    .raddr (cout),
    .rdata (bias)
  );

endmodule

// File: doc/bias_ram_loader.md
# bias_ram_loader

Write-side counterpart of the conv-layer bias ROM reader: accepts a byte stream of per-output-channel biases over a valid/ready handshake, checks a trailing 8-bit checksum, and stores the biases in an internal RAM. The RAM is exposed through the same `c_load`/`cout` → `bias` read port that the conv datapath already uses. A host or UART front-end can then reload biases at run time instead of relying on a fixed `$readmemh` image.

## Interface
- `OC`, 7, out_channels − 1; RAM depth is OC+1; OC ≤ 15.
- `DW`, 8, bias/data width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load; ignored unless idle.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  DW  stream byte.
- `s_ready`  out  1  stream ready; a byte is accepted when `s_valid && s_ready`.
- `busy`  out  1  high from the cycle after an accepted `start` until the checksum byte is consumed.
- `done`  out  1  one-cycle pulse after the checksum byte is consumed.
- `err`  out  1  checksum mismatch on the last load; held until the next accepted `start` or reset.
- `loaded`  out  1  RAM holds a checksum-verified table.
- `c_load`  in  1  read strobe from the conv control.
- `cout`  in  4  output channel to read.
- `bias`  out  DW  registered read data.

## Operation
- FSM states: IDLE, LOAD, CSUM.
  - IDLE: `start` → LOAD. On that edge: `addr`←0, `sum`←0, `err`←0, `loaded`←0.
  - LOAD: each accepted byte is written to `mem[addr]`; `sum`←`sum`+byte (mod 2^DW); `addr`++. The byte accepted at `addr`==OC moves the FSM to CSUM.
  - CSUM: on the accepted byte, `err`←(byte ≠ `sum`), `loaded`←(byte == `sum`), `done`←1, FSM → IDLE.
- `s_ready` = (state ≠ IDLE), driven combinationally from the state register. No stall is ever inserted.
- `start` is ignored in LOAD and CSUM. A load cannot be aborted except by `rst`.
- Rejected table: RAM contents are not rolled back; `loaded` stays 0 until a successful reload.
- Read port: on `c_load`, `bias`←`mem[cout]`. If `cout` > OC, `bias`←0. Without `c_load`, `bias` holds its value.
- Reads are allowed in any state. A read and a write to the same address in the same cycle return the old data (read-before-write).
- RAM contents are not reset. Reads before the first load return undefined data; consumers must gate on `loaded`.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `busy`=0, `done`=0, `err`=0, `loaded`=0, `bias`=0, `addr`=0, `sum`=0.
- `start` at cycle t → `s_ready`=1 and `busy`=1 at t+1.
- A back-to-back stream takes OC+2 accepted bytes. With every byte valid, `done` pulses one cycle after the checksum byte is accepted, and `busy` drops in that same cycle.
- `err` and `loaded` become valid in the same cycle as `done`.
- Read latency: `bias` is valid the cycle after `c_load`.
- `rst` mid-load: returns to IDLE with all reset values. A partial RAM write is left in place; `loaded`=0.
- `s_valid` may drop at any point; the FSM waits indefinitely with state, `addr` and `sum` held.

## Structure
- Shared package `cnn_pkg` holds:
  - the `DW` and default `OC` constants;
  - the FSM state typedef `bias_ld_state_t` {IDLE, LOAD, CSUM}.
- One sub-module, `bias_ram`: a (OC+1)×DW array with one synchronous write port, one registered read port, read-before-write ordering, and out-of-range reads returning 0.
- The top level contains the FSM, the address counter, the checksum accumulator and the status flags.

## Test plan
- Reset, then `c_load`=1, `cout`=0 → `bias`=0, `loaded`=0, `s_ready`=0.
- Load 01,02,…,08 with checksum 24h, streaming back-to-back → `done` pulses once 9 cycles after the first accept, `loaded`=1, `err`=0; reading `cout`=5 returns 06h.
- Same bytes with checksum 25h → `done` pulse, `err`=1, `loaded`=0; `err` clears on the next `start`.
- Sum wrap-around: load eight bytes of FFh with checksum F8h → `loaded`=1.
- Random `s_valid` gaps, and a `start` pulse mid-load → byte count, `done` timing relative to the last accept, and RAM contents unaffected by the stray `start`.
- `rst` after 4 bytes, then a full good load of 10h..17h (checksum 9Ch) → `loaded`=1; `cout`=3 reads 13h. `cout`=9 reads 00h. A read of address 2 in the same cycle as its write returns the previous value.
